// File: rtl/core_ibex_debug_stim_ctrl.sv
// Debug stimulus sequencer: releases fetch after a boot delay, then issues debug requests
// and waits for the core's dret (or flags a hang) between them.
module core_ibex_debug_stim_ctrl #(
    parameter int unsigned CntW        = 16,
    parameter int unsigned BootDelay   = 8,
    parameter int unsigned DretTimeout = 4096,
    parameter int unsigned NumReqW     = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [CntW-1:0]    interval_i,
    input  logic [CntW-1:0]    hold_i,
    input  logic               single_i,
    input  logic               dret_i,
    input  logic               reset_i,
    output logic               fetch_enable_o,
    output logic               debug_req_o,
    output logic               busy_o,
    output logic               timeout_o,
    output logic [NumReqW-1:0] dbg_count_o
);

    localparam int unsigned TmoW = (DretTimeout > 1) ? $clog2(DretTimeout) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] BOOT     = 3'd1;
    localparam logic [2:0] WAIT     = 3'd2;
    localparam logic [2:0] REQ      = 3'd3;
    localparam logic [2:0] IN_DEBUG = 3'd4;
    localparam logic [2:0] POST     = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;
    localparam logic [2:0] ERR      = 3'd7;

    logic [2:0]         state_q;
    logic [CntW-1:0]    cnt_q;
    logic [CntW-1:0]    interval_q;
    logic [CntW-1:0]    hold_q;
    logic               single_q;
    logic               stop_pend_q;
    logic               dret_seen_q;
    logic [TmoW-1:0]    tmo_q;
    logic               fetch_q;
    logic               req_q;
    logic               timeout_q;
    logic [NumReqW-1:0] count_q;

    // A programmed length of zero behaves as one cycle; counters run down to zero.
    function automatic logic [CntW-1:0] load_cnt(input logic [CntW-1:0] v);
        return (v == '0) ? '0 : v - CntW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            interval_q  <= '0;
            hold_q      <= '0;
            single_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            dret_seen_q <= 1'b0;
            tmo_q       <= '0;
            fetch_q     <= 1'b0;
            req_q       <= 1'b0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
        end else if (reset_i) begin
            // DUT-side reset: drop stimulus but keep the request count and hang flag.
            state_q     <= IDLE;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            dret_seen_q <= 1'b0;
            fetch_q     <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        state_q     <= BOOT;
                        cnt_q       <= CntW'(BootDelay - 1);
                        interval_q  <= interval_i;
                        hold_q      <= hold_i;
                        single_q    <= single_i;
                        stop_pend_q <= 1'b0;
                    end
                end
                BOOT: begin
                    if (stop_i) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        fetch_q <= 1'b1;
                        if (stop_pend_q || stop_i) begin
                            state_q     <= DONE;
                            stop_pend_q <= 1'b0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= load_cnt(interval_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                WAIT: begin
                    if (stop_i) begin
                        state_q <= DONE;
                    end else if (cnt_q == '0) begin
                        state_q     <= REQ;
                        req_q       <= 1'b1;
                        cnt_q       <= load_cnt(hold_q);
                        dret_seen_q <= 1'b0;
                        if (count_q != '1) begin
                            count_q <= count_q + NumReqW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                REQ: begin
                    // Stop and an early dret are remembered; the hold always runs to completion.
                    if (stop_i) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (dret_i) begin
                        dret_seen_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        req_q <= 1'b0;
                        if (dret_seen_q || dret_i) begin
                            state_q <= POST;
                        end else begin
                            state_q <= IN_DEBUG;
                            tmo_q   <= TmoW'(DretTimeout - 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                IN_DEBUG: begin
                    if (stop_i) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (dret_i) begin
                        state_q <= POST;
                    end else if (tmo_q == '0) begin
                        state_q   <= ERR;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - TmoW'(1);
                    end
                end
                POST: begin
                    if (single_q || stop_i || stop_pend_q) begin
                        state_q     <= DONE;
                        stop_pend_q <= 1'b0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= load_cnt(interval_q);
                    end
                end
                DONE: begin
                    req_q <= 1'b0;
                    if (start_i) begin
                        state_q     <= BOOT;
                        cnt_q       <= CntW'(BootDelay - 1);
                        interval_q  <= interval_i;
                        hold_q      <= hold_i;
                        single_q    <= single_i;
                        stop_pend_q <= 1'b0;
                    end
                end
                ERR: begin
                    req_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fetch_enable_o = fetch_q;
    assign debug_req_o    = req_q;
    assign busy_o         = (state_q != IDLE);
    assign timeout_o      = timeout_q;
    assign dbg_count_o    = count_q;

endmodule

// File: tb/tb_core_ibex_debug_stim_ctrl.sv
// Bench for core_ibex_debug_stim_ctrl: randomized sequences checked against an
// edge-schedule model of when fetch, requests and the count must change.
module tb_core_ibex_debug_stim_ctrl;

    localparam int CntW        = 16;
    localparam int BootDelay   = 8;
    localparam int DretTimeout = 4096;
    localparam int NumReqW     = 8;
    localparam int MaxCount    = (1 << NumReqW) - 1;

    logic               clk_i;
    logic               rst_ni;
    logic               start_i;
    logic               stop_i;
    logic [CntW-1:0]    interval_i;
    logic [CntW-1:0]    hold_i;
    logic               single_i;
    logic               dret_i;
    logic               reset_i;
    logic               fetch_enable_o;
    logic               debug_req_o;
    logic               busy_o;
    logic               timeout_o;
    logic [NumReqW-1:0] dbg_count_o;

    int checks;
    int passes;
    int expCount;
    bit fetchOn;

    core_ibex_debug_stim_ctrl #(
        .CntW        (CntW),
        .BootDelay   (BootDelay),
        .DretTimeout (DretTimeout),
        .NumReqW     (NumReqW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .interval_i     (interval_i),
        .hold_i         (hold_i),
        .single_i       (single_i),
        .dret_i         (dret_i),
        .reset_i        (reset_i),
        .fetch_enable_o (fetch_enable_o),
        .debug_req_o    (debug_req_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o),
        .dbg_count_o    (dbg_count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    function automatic int satCount(input int v);
        return (v > MaxCount) ? MaxCount : v;
    endfunction

    task automatic checkAll(input string tag, input bit fetch, input bit req, input bit busy,
                            input int count, input bit tmo);
        checkOutput({tag, ".fetch"}, 32'(fetch_enable_o), 32'(fetch));
        checkOutput({tag, ".req"}, 32'(debug_req_o), 32'(req));
        checkOutput({tag, ".busy"}, 32'(busy_o), 32'(busy));
        checkOutput({tag, ".count"}, 32'(dbg_count_o), count);
        checkOutput({tag, ".tmo"}, 32'(timeout_o), 32'(tmo));
    endtask

    // Edge 0 is the edge that samples start. From the config and the chosen dret delays the
    // model lays out the edge of every request rise, dret pulse and the final DONE entry.
    task automatic applyStimulus(input int interval, input int hold, input bit single,
                                 input int nReq, input int minD, input int maxD);
        int iEff, hEff, w, d, r, doneEdge, stopEdge, hits;
        int rq[$];
        int dretAt[$];
        bit reqExp, dretNow;
        iEff = (interval == 0) ? 1 : interval;
        hEff = (hold == 0) ? 1 : hold;
        if (single) nReq = 1;
        w = BootDelay;
        for (int k = 0; k < nReq; k++) begin
            r = w + iEff;
            rq.push_back(r);
            d = $urandom_range(maxD, minD);
            if (d == 0) dretAt.push_back(r + 1 + $urandom_range(hEff - 1, 0));
            else        dretAt.push_back(r + hEff + d);
            w = r + hEff + d + 1;
        end
        doneEdge = w;
        stopEdge = single ? 32'h7fffffff : $urandom_range(doneEdge, rq[nReq-1] + 1);

        interval_i = CntW'(interval);
        hold_i     = CntW'(hold);
        single_i   = single;
        stop_i     = 1'b0;
        dret_i     = 1'b0;
        start_i    = 1'b1;
        for (int e = 0; e <= doneEdge + 3; e++) begin
            stepEdge();
            if (e == 0) begin
                start_i    = 1'b0;
                interval_i = CntW'($urandom);
                hold_i     = CntW'($urandom);
                single_i   = 1'($urandom);
            end
            hits   = 0;
            reqExp = 1'b0;
            foreach (rq[k]) begin
                if (rq[k] <= e) hits++;
                if (rq[k] <= e && e < rq[k] + hEff) reqExp = 1'b1;
            end
            checkAll($sformatf("seq@%0d", e), fetchOn || e >= BootDelay, reqExp, 1'b1,
                     satCount(expCount + hits), 1'b0);
            dretNow = 1'b0;
            foreach (dretAt[k]) if (dretAt[k] == e + 1) dretNow = 1'b1;
            dret_i = dretNow;
            stop_i = (e + 1 >= stopEdge);
        end
        stop_i   = 1'b0;
        dret_i   = 1'b0;
        expCount = satCount(expCount + nReq);
        fetchOn  = 1'b1;
    endtask

    initial begin
        int tEdge;
        checks     = 0;
        passes     = 0;
        expCount   = 0;
        fetchOn    = 1'b0;
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        interval_i = '0;
        hold_i     = '0;
        single_i   = 1'b0;
        dret_i     = 1'b0;
        reset_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        checkAll("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst_ni = 1'b1;
        stepEdge();
        checkAll("idle", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        start_i = 1'b1;
        stop_i  = 1'b1;
        stepEdge();
        start_i = 1'b0;
        stop_i  = 1'b0;
        checkAll("idle.startstop", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        applyStimulus(5, 3, 1'b1, 1, 10, 10);
        applyStimulus(0, 0, 1'b0, 3, 2, 2);
        repeat (8) begin
            applyStimulus($urandom_range(6, 0), $urandom_range(4, 0), 1'($urandom),
                          $urandom_range(4, 1), 0, 4);
        end

        // reset_i while waiting for dret
        interval_i = CntW'(1);
        hold_i     = CntW'(1);
        single_i   = 1'b0;
        start_i    = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            stepEdge();
            if (e == 0) start_i = 1'b0;
            if (e == 10) checkAll("indebug", 1'b1, 1'b0, 1'b1, satCount(expCount + 1), 1'b0);
        end
        reset_i = 1'b1;
        stepEdge();
        reset_i  = 1'b0;
        expCount = satCount(expCount + 1);
        fetchOn  = 1'b0;
        checkAll("rsti.indebug", 1'b0, 1'b0, 1'b0, expCount, 1'b0);

        repeat (3) begin
            applyStimulus($urandom_range(6, 0), $urandom_range(4, 0), 1'($urandom),
                          $urandom_range(3, 1), 0, 4);
        end

        // No dret: hang detection, ERR ignores start, reset_i keeps the flag, rst_ni clears it
        interval_i = CntW'(2);
        hold_i     = CntW'(2);
        single_i   = 1'b1;
        start_i    = 1'b1;
        tEdge      = BootDelay + 2 + 2 + DretTimeout;
        for (int e = 0; e <= tEdge; e++) begin
            stepEdge();
            if (e == 0) start_i = 1'b0;
            if (e == BootDelay + 2) checkOutput("tmo.req", 32'(debug_req_o), 32'd1);
            if (e == tEdge - 1) checkOutput("tmo.before", 32'(timeout_o), 32'd0);
        end
        expCount = satCount(expCount + 1);
        checkAll("tmo.err", 1'b1, 1'b0, 1'b1, expCount, 1'b1);
        start_i = 1'b1;
        stepEdge();
        start_i = 1'b0;
        repeat (11) stepEdge();
        checkAll("err.start", 1'b1, 1'b0, 1'b1, expCount, 1'b1);
        reset_i = 1'b1;
        stepEdge();
        reset_i = 1'b0;
        fetchOn = 1'b0;
        checkAll("rsti.err", 1'b0, 1'b0, 1'b0, expCount, 1'b1);
        rst_ni = 1'b0;
        #1;
        checkAll("rstn", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        expCount = 0;
        stepEdge();
        rst_ni = 1'b1;
        stepEdge();

        applyStimulus(1, 1, 1'b0, 256, 0, 0);
        applyStimulus(3, 2, 1'b1, 1, 0, 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
